// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial-stream, pattern-load and status bundle for seq_detector_param; SEQ_DET_MATCH_CNT_EN adds the counter signals
interface seq_detector_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic                             seq_valid;
  logic                             seq_in;
  logic                             overlap_en;
  logic                             pat_load;
  logic [PAT_LEN-1:0]               pat_in;
  logic                             detect_out;
  logic [$clog2(PAT_LEN+1)-1:0]     fill_cnt;
  if (CNT_W < 1) $error("CNT_W must be at least 1");
`ifdef SEQ_DET_MATCH_CNT_EN
  logic                             cnt_clr;
  logic [CNT_W-1:0]                 match_cnt;
  modport master (output seq_valid, seq_in, overlap_en, pat_load, pat_in, cnt_clr,
                  input  detect_out, fill_cnt, match_cnt);
  modport slave  (input  seq_valid, seq_in, overlap_en, pat_load, pat_in, cnt_clr,
                  output detect_out, fill_cnt, match_cnt);
`else
  modport master (output seq_valid, seq_in, overlap_en, pat_load, pat_in,
                  input  detect_out, fill_cnt);
  modport slave  (input  seq_valid, seq_in, overlap_en, pat_load, pat_in,
                  output detect_out, fill_cnt);
`endif
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-loadable serial pattern detector, overlap/non-overlap modes
// Optional saturating match counter when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detector_param #(
  parameter int                 PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] RST_PATTERN = 4'b1011,
  parameter int                 CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_param_if.slave  bus
);
  localparam int FW = $clog2(PAT_LEN+1);
  localparam logic [FW-1:0] ARM = FW'(PAT_LEN-1);
  if (PAT_LEN < 2) $error("PAT_LEN must be at least 2");
  if (CNT_W < 1) $error("CNT_W must be at least 1");
  typedef enum logic {FILL, ARMED} state_t;
  state_t             state_q;
  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-2:0] hist_q;
  logic [FW-1:0]      fill_q;
  logic               det_q;
  logic [PAT_LEN-1:0] window;
  logic               match;
  assign window = {hist_q, bus.seq_in};
  assign match = state_q == ARMED && window == pat_q;
  assign bus.detect_out = det_q;
  assign bus.fill_cnt = fill_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      pat_q <= RST_PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      det_q <= 1'b0;
    end else if (bus.pat_load) begin
      state_q <= FILL;
      pat_q <= bus.pat_in;
      hist_q <= '0;
      fill_q <= '0;
      det_q <= 1'b0;
    end else if (bus.seq_valid) begin
      hist_q <= window[PAT_LEN-2:0];
      det_q <= match;
      // non-overlapping mode restarts the fill so the next hit needs PAT_LEN fresh bits
      if (match && !bus.overlap_en) begin
        state_q <= FILL;
        fill_q <= '0;
      end else if (state_q == FILL) begin
        state_q <= fill_q == ARM - 1'b1 ? ARMED : FILL;
        fill_q <= fill_q + 1'b1;
      end
    end else begin
      det_q <= 1'b0;
    end
  end
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  assign bus.match_cnt = cnt_q;
  always_ff @(posedge clk) begin
    if (reset || bus.cnt_clr) cnt_q <= '0;
    else if (det_q && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end
`endif
  always @(posedge clk) begin
    if (!reset) begin
      assert (fill_q <= ARM);
      assert ((state_q == ARMED) == (fill_q == ARM));
    end
  end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed and random checks of seq_detector_param against a queue-based model
module tb_seq_detector_param;
  localparam int L = 4;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic exp_det = 1'b0;
  logic [L-1:0] mpat = 4'b1011;
  bit q[$];
  int mcnt = 0;
  seq_detector_param_if #(.PAT_LEN(L), .CNT_W(CW)) bus();
  seq_detector_param #(.PAT_LEN(L), .RST_PATTERN(4'b1011), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, v, b, o, l, input logic [L-1:0] p, input logic c);
    int w;
    reset = r;
    bus.seq_valid = v;
    bus.seq_in = b;
    bus.overlap_en = o;
    bus.pat_load = l;
    bus.pat_in = p;
`ifdef SEQ_DET_MATCH_CNT_EN
    bus.cnt_clr = c;
`endif
    @(posedge clk);
    mcnt = (r || c) ? 0 : (exp_det && mcnt < (1 << CW) - 1) ? mcnt + 1 : mcnt;
    if (r) begin
      mpat = 4'b1011;
      q.delete();
      exp_det = 1'b0;
    end else if (l) begin
      mpat = p;
      q.delete();
      exp_det = 1'b0;
    end else if (v) begin
      q.push_back(b);
      if (q.size() > L) void'(q.pop_front());
      w = 0;
      if (q.size() == L) for (int i = 0; i < L; i++) w = w * 2 + int'(q[i]);
      exp_det = q.size() == L && w == int'(mpat);
      if (exp_det && !o) q.delete();
    end else begin
      exp_det = 1'b0;
    end
    #1;
    chk("detect_out", int'(bus.detect_out), int'(exp_det));
    chk("fill_cnt", int'(bus.fill_cnt), q.size() > L - 1 ? L - 1 : q.size());
`ifdef SEQ_DET_MATCH_CNT_EN
    chk("match_cnt", int'(bus.match_cnt), mcnt);
`endif
    if (bus.detect_out) pulses++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, 0);
  endtask
  task automatic send(input logic [15:0] s, input int n, input logic o, input int gap);
    for (int i = 0; i < n; i++) begin
      step(0, 1, s[n-1-i], o, 0, '0, 0);
      idle(gap);
    end
  endtask
  task automatic rst1();
    step(1, 0, 0, 0, 0, '0, 0);
    pulses = 0;
  endtask
  initial begin
    bus.seq_valid = 0;
    bus.seq_in = 0;
    bus.overlap_en = 0;
    bus.pat_load = 0;
    bus.pat_in = '0;
`ifdef SEQ_DET_MATCH_CNT_EN
    bus.cnt_clr = 0;
`endif
    rst1();
    rst1();
    chk("reset_detect", int'(bus.detect_out), 0);
    chk("reset_fill", int'(bus.fill_cnt), 0);
    send(16'b1011, 4, 0, 0);
    idle(1);
    chk("t1_pulses", pulses, 1);
    rst1();
    send(16'b1011011, 7, 0, 0);
    idle(1);
    chk("t2_nonovl_pulses", pulses, 1);
    rst1();
    send(16'b1011011, 7, 1, 0);
    idle(1);
    chk("t2_ovl_pulses", pulses, 2);
    rst1();
    send(16'b1011, 4, 0, 3);
    chk("t3_gap_pulses", pulses, 1);
    step(0, 1, 1, 0, 1, 4'b0110, 0);
    chk("t4_load_fill", int'(bus.fill_cnt), 0);
    pulses = 0;
    send(16'b0110, 4, 0, 0);
    idle(1);
    chk("t4_new_pat_pulses", pulses, 1);
    pulses = 0;
    send(16'b1011, 4, 0, 0);
    idle(1);
    chk("t4_old_pat_pulses", pulses, 0);
    rst1();
    send(16'b101, 3, 0, 0);
    rst1();
    send(16'b1, 1, 0, 0);
    idle(1);
    chk("t5_pulses", pulses, 0);
    chk("t5_fill", int'(bus.fill_cnt), 1);
`ifdef SEQ_DET_MATCH_CNT_EN
    rst1();
    for (int k = 0; k < 5; k++) send(16'b1011, 4, 0, 0);
    idle(1);
    chk("t6_sat_cnt", int'(bus.match_cnt), 3);
    step(0, 0, 0, 0, 0, '0, 1);
    chk("t6_clr_cnt", int'(bus.match_cnt), 0);
`endif
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 127) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
           1'($urandom), $urandom_range(0, 63) == 0, L'($urandom),
           $urandom_range(0, 99) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
